// File: rtl/pc_fetch_pkg.sv
// Shared definitions for the PC / instruction-fetch stage.
package pc_fetch_pkg;

   localparam logic [31:0] RESET_PC    = 32'hBFC0_0000;
   localparam int          EXC_ADEL_IF = 4;
   localparam int          STALL_W     = 6;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2,
      S_HOLD = 2'd3
   } fetch_state_t;

   function automatic logic is_misaligned(input logic [31:0] addr);
      return addr[1:0] != 2'b00;
   endfunction

endpackage

// File: rtl/pc_fetch_redirect_buf.sv
// One-entry pending redirect: remembers a branch or flush target until the
// fetch FSM next advances the PC. A flush overwrites a pending branch; a
// branch never overwrites a pending flush.
module pc_redirect_buf (
   input  logic        clk,
   input  logic        rst,
   input  logic        clear,
   input  logic        set_flush,
   input  logic        set_branch,
   input  logic [31:0] flush_addr,
   input  logic [31:0] branch_addr,
   output logic        valid,
   output logic [31:0] addr
);

   logic is_flush;

   // Pending-entry register; clear (PC advance) wins over any new request.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid    <= 1'b0;
         is_flush <= 1'b0;
         addr     <= 32'h0;
      end else if (clear) begin
         valid    <= 1'b0;
         is_flush <= 1'b0;
      end else if (set_flush) begin
         valid    <= 1'b1;
         is_flush <= 1'b1;
         addr     <= flush_addr;
      end else if (set_branch && !(valid && is_flush)) begin
         valid    <= 1'b1;
         is_flush <= 1'b0;
         addr     <= branch_addr;
      end
   end

endmodule

// File: rtl/pc_fetch.sv
// PC register and instruction-fetch handshake with the icache.
//
// state  | meaning
// IDLE   | after reset, waiting for stall[0] to drop
// REQ    | inst_req driven with PC, waiting for inst_addr_ok
// WAIT   | request accepted, waiting for inst_data_ok
// HOLD   | fetched word (or address fault) presented to IF/ID
module pc_fetch
   import pc_fetch_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic [STALL_W-1:0] stall,
   input  logic               flush,
   input  logic [31:0]        new_pc,
   input  logic               branch_flag,
   input  logic [31:0]        branch_target,
   output logic               inst_req,
   output logic [31:0]        inst_addr,
   input  logic               inst_addr_ok,
   input  logic               inst_data_ok,
   input  logic [31:0]        inst_rdata,
   output logic [31:0]        if_pc,
   output logic [31:0]        if_inst,
   output logic [31:0]        icache_excepttype,
   output logic               stallreq_if
);

   fetch_state_t state, state_n;
   logic [31:0]  pc, pc_n;
   logic [31:0]  inst_buf, inst_buf_n;
   logic         exc, exc_n;
   logic         discard, discard_n;

   logic         go;
   logic [31:0]  go_addr;
   logic         pend_clear, pend_set_flush, pend_set_branch;
   logic         pend_valid;
   logic [31:0]  pend_addr;
   logic         unused_stall;

   assign unused_stall = ^stall[STALL_W-1:2];

   pc_redirect_buf u_redirect (
      .clk         (clk),
      .rst         (rst),
      .clear       (pend_clear),
      .set_flush   (pend_set_flush),
      .set_branch  (pend_set_branch),
      .flush_addr  (new_pc),
      .branch_addr (branch_target),
      .valid       (pend_valid),
      .addr        (pend_addr)
   );

   // State and datapath registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= S_IDLE;
         pc       <= RESET_PC;
         inst_buf <= 32'h0;
         exc      <= 1'b0;
         discard  <= 1'b0;
      end else begin
         state    <= state_n;
         pc       <= pc_n;
         inst_buf <= inst_buf_n;
         exc      <= exc_n;
         discard  <= discard_n;
      end
   end

   // Next-state logic; "go" starts a fresh fetch at go_addr, where a
   // misaligned target skips the icache and faults straight into HOLD.
   always_comb begin
      state_n         = state;
      pc_n            = pc;
      inst_buf_n      = inst_buf;
      exc_n           = exc;
      discard_n       = discard;
      go              = 1'b0;
      go_addr         = pc;
      pend_clear      = 1'b0;
      pend_set_flush  = 1'b0;
      pend_set_branch = 1'b0;

      case (state)
         S_IDLE: begin
            if (flush) begin
               go      = 1'b1;
               go_addr = new_pc;
            end else if (!stall[0]) begin
               go      = 1'b1;
               go_addr = pc;
            end
         end
         S_REQ: begin
            if (inst_addr_ok) begin
               if (inst_data_ok) begin
                  if (flush) begin
                     go      = 1'b1;
                     go_addr = new_pc;
                  end else begin
                     inst_buf_n      = inst_rdata;
                     state_n         = S_HOLD;
                     pend_set_branch = branch_flag;
                  end
               end else begin
                  state_n         = S_WAIT;
                  discard_n       = flush;
                  pend_set_flush  = flush;
                  pend_set_branch = branch_flag;
               end
            end else if (flush) begin
               // not yet accepted, so simply re-aim the request
               go      = 1'b1;
               go_addr = new_pc;
            end else begin
               pend_set_branch = branch_flag;
            end
         end
         S_WAIT: begin
            if (inst_data_ok) begin
               if (flush) begin
                  go      = 1'b1;
                  go_addr = new_pc;
               end else if (discard) begin
                  go      = 1'b1;
                  go_addr = pend_addr;
               end else begin
                  inst_buf_n      = inst_rdata;
                  state_n         = S_HOLD;
                  pend_set_branch = branch_flag;
               end
            end else begin
               if (flush) discard_n = 1'b1;
               pend_set_flush  = flush;
               pend_set_branch = branch_flag;
            end
         end
         S_HOLD: begin
            if (flush) begin
               go      = 1'b1;
               go_addr = new_pc;
            end else if (!stall[1]) begin
               go = 1'b1;
               if (branch_flag)     go_addr = branch_target;
               else if (pend_valid) go_addr = pend_addr;
               else                 go_addr = pc + 32'd4;
            end else begin
               pend_set_branch = branch_flag;
            end
         end
         default: state_n = S_IDLE;
      endcase

      if (go) begin
         pc_n       = go_addr;
         pend_clear = 1'b1;
         discard_n  = 1'b0;
         if (is_misaligned(go_addr)) begin
            state_n    = S_HOLD;
            exc_n      = 1'b1;
            inst_buf_n = 32'h0;
         end else begin
            state_n = S_REQ;
            exc_n   = 1'b0;
         end
      end
   end

   // Outputs are pure functions of the registered state.
   always_comb begin
      inst_req          = (state == S_REQ);
      inst_addr         = (state == S_REQ)  ? pc : 32'h0;
      if_pc             = (state == S_HOLD) ? pc : 32'h0;
      if_inst           = (state == S_HOLD) ? inst_buf : 32'h0;
      icache_excepttype = (state == S_HOLD && exc) ? (32'h1 << EXC_ADEL_IF) : 32'h0;
      stallreq_if       = (state == S_REQ) || (state == S_WAIT);
   end

endmodule

// File: tb/tb_pc_fetch.sv
// Directed bench for pc_fetch: a per-cycle vector table followed by
// hand-written reset sequences.
module tb_pc_fetch;

   logic        clk = 1'b0;
   logic        rst;
   logic [5:0]  stall;
   logic        flush;
   logic [31:0] new_pc;
   logic        branch_flag;
   logic [31:0] branch_target;
   logic        inst_req;
   logic [31:0] inst_addr;
   logic        inst_addr_ok;
   logic        inst_data_ok;
   logic [31:0] inst_rdata;
   logic [31:0] if_pc;
   logic [31:0] if_inst;
   logic [31:0] icache_excepttype;
   logic        stallreq_if;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   pc_fetch dut (
      .clk               (clk),
      .rst               (rst),
      .stall             (stall),
      .flush             (flush),
      .new_pc            (new_pc),
      .branch_flag       (branch_flag),
      .branch_target     (branch_target),
      .inst_req          (inst_req),
      .inst_addr         (inst_addr),
      .inst_addr_ok      (inst_addr_ok),
      .inst_data_ok      (inst_data_ok),
      .inst_rdata        (inst_rdata),
      .if_pc             (if_pc),
      .if_inst           (if_inst),
      .icache_excepttype (icache_excepttype),
      .stallreq_if       (stallreq_if)
   );

   typedef struct {
      logic [5:0]  stall;
      logic        flush;
      logic [31:0] new_pc;
      logic        br;
      logic [31:0] br_t;
      logic        aok;
      logic        dok;
      logic [31:0] rdata;
      logic        e_req;
      logic [31:0] e_addr;
      logic [31:0] e_pc;
      logic [31:0] e_inst;
      logic [31:0] e_exc;
      logic        e_sr;
   } vec_t;

   localparam int NV = 24;
   vec_t vecs [NV];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic e_req, input logic [31:0] e_addr,
                          input logic [31:0] e_pc, input logic [31:0] e_inst,
                          input logic [31:0] e_exc, input logic e_sr);
      chk({tag, " inst_req"},    {31'h0, inst_req},    {31'h0, e_req});
      chk({tag, " inst_addr"},   inst_addr,            e_addr);
      chk({tag, " if_pc"},       if_pc,                e_pc);
      chk({tag, " if_inst"},     if_inst,              e_inst);
      chk({tag, " excepttype"},  icache_excepttype,    e_exc);
      chk({tag, " stallreq_if"}, {31'h0, stallreq_if}, {31'h0, e_sr});
   endtask

   task automatic drive_idle();
      stall = 6'd0; flush = 1'b0; new_pc = 32'h0;
      branch_flag = 1'b0; branch_target = 32'h0;
      inst_addr_ok = 1'b0; inst_data_ok = 1'b0; inst_rdata = 32'h0;
   endtask

   initial begin
      //          stall  fl  new_pc        br  br_t          aok dok rdata        | req addr          if_pc         if_inst       exc          sr
      vecs[0]  = '{6'd0, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0,        0, 32'h0,        32'h0,        32'h0,        32'h0,  0};
      vecs[1]  = '{6'd0, 0, 32'h0,        0, 32'h0,        1, 0, 32'h0,        1, 32'hBFC00000, 32'h0,        32'h0,        32'h0,  1};
      vecs[2]  = '{6'd0, 0, 32'h0,        0, 32'h0,        0, 1, 32'h11111111, 0, 32'h0,        32'h0,        32'h0,        32'h0,  1};
      vecs[3]  = '{6'd0, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0,        0, 32'h0,        32'hBFC00000, 32'h11111111, 32'h0,  0};
      vecs[4]  = '{6'd0, 0, 32'h0,        0, 32'h0,        1, 0, 32'h0,        1, 32'hBFC00004, 32'h0,        32'h0,        32'h0,  1};
      vecs[5]  = '{6'd0, 0, 32'h0,        1, 32'hBFC00100, 0, 0, 32'h0,        0, 32'h0,        32'h0,        32'h0,        32'h0,  1};
      vecs[6]  = '{6'd1, 0, 32'h0,        0, 32'h0,        0, 1, 32'h22222222, 0, 32'h0,        32'h0,        32'h0,        32'h0,  1};
      vecs[7]  = '{6'd0, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0,        0, 32'h0,        32'hBFC00004, 32'h22222222, 32'h0,  0};
      vecs[8]  = '{6'd0, 0, 32'h0,        0, 32'h0,        1, 1, 32'h33333333, 1, 32'hBFC00100, 32'h0,        32'h0,        32'h0,  1};
      vecs[9]  = '{6'd2, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0,        0, 32'h0,        32'hBFC00100, 32'h33333333, 32'h0,  0};
      vecs[10] = '{6'd2, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0,        0, 32'h0,        32'hBFC00100, 32'h33333333, 32'h0,  0};
      vecs[11] = '{6'd2, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0,        0, 32'h0,        32'hBFC00100, 32'h33333333, 32'h0,  0};
      vecs[12] = '{6'd0, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0,        0, 32'h0,        32'hBFC00100, 32'h33333333, 32'h0,  0};
      vecs[13] = '{6'd0, 0, 32'h0,        0, 32'h0,        1, 0, 32'h0,        1, 32'hBFC00104, 32'h0,        32'h0,        32'h0,  1};
      vecs[14] = '{6'd0, 1, 32'hBFC00380, 0, 32'h0,        0, 0, 32'h0,        0, 32'h0,        32'h0,        32'h0,        32'h0,  1};
      vecs[15] = '{6'd0, 0, 32'h0,        0, 32'h0,        0, 1, 32'hDEADBEEF, 0, 32'h0,        32'h0,        32'h0,        32'h0,  1};
      vecs[16] = '{6'd0, 1, 32'hBFC00400, 0, 32'h0,        0, 0, 32'h0,        1, 32'hBFC00380, 32'h0,        32'h0,        32'h0,  1};
      vecs[17] = '{6'd0, 0, 32'h0,        0, 32'h0,        1, 1, 32'h44444444, 1, 32'hBFC00400, 32'h0,        32'h0,        32'h0,  1};
      vecs[18] = '{6'd0, 0, 32'h0,        1, 32'hBFC00102, 0, 0, 32'h0,        0, 32'h0,        32'hBFC00400, 32'h44444444, 32'h0,  0};
      vecs[19] = '{6'd2, 1, 32'hFFFFFFFC, 0, 32'h0,        0, 0, 32'h0,        0, 32'h0,        32'hBFC00102, 32'h0,        32'h10, 0};
      vecs[20] = '{6'd0, 0, 32'h0,        0, 32'h0,        1, 1, 32'h55555555, 1, 32'hFFFFFFFC, 32'h0,        32'h0,        32'h0,  1};
      vecs[21] = '{6'd0, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0,        0, 32'h0,        32'hFFFFFFFC, 32'h55555555, 32'h0,  0};
      vecs[22] = '{6'h3F,0, 32'h0,        0, 32'h0,        1, 0, 32'h0,        1, 32'h00000000, 32'h0,        32'h0,        32'h0,  1};
      vecs[23] = '{6'd0, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0,        0, 32'h0,        32'h0,        32'h0,        32'h0,  1};

      rst = 1'b1;
      drive_idle();
      #1;
      chk_all("reset", 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
      tick();
      tick();
      rst = 1'b0;

      for (int i = 0; i < NV; i++) begin
         stall         = vecs[i].stall;
         flush         = vecs[i].flush;
         new_pc        = vecs[i].new_pc;
         branch_flag   = vecs[i].br;
         branch_target = vecs[i].br_t;
         inst_addr_ok  = vecs[i].aok;
         inst_data_ok  = vecs[i].dok;
         inst_rdata    = vecs[i].rdata;
         chk_all($sformatf("row%0d", i), vecs[i].e_req, vecs[i].e_addr, vecs[i].e_pc,
                 vecs[i].e_inst, vecs[i].e_exc, vecs[i].e_sr);
         tick();
      end

      // Asynchronous reset while in WAIT, with a late data_ok afterwards.
      drive_idle();
      #2;
      rst = 1'b1;
      #1;
      chk_all("async_rst", 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
      tick();
      rst          = 1'b0;
      stall        = 6'd1;
      inst_data_ok = 1'b1;
      inst_rdata   = 32'hBAD0BAD0;
      tick();
      chk_all("idle_late_dok", 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
      inst_data_ok = 1'b0;
      tick();
      chk_all("idle_stalled", 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
      stall = 6'd0;
      tick();
      chk_all("restart_req", 1'b1, 32'hBFC00000, 32'h0, 32'h0, 32'h0, 1'b1);
      inst_data_ok = 1'b1;
      inst_rdata   = 32'hBAD1BAD1;
      tick();
      chk_all("req_stray_dok", 1'b1, 32'hBFC00000, 32'h0, 32'h0, 32'h0, 1'b1);
      inst_data_ok = 1'b0;
      inst_addr_ok = 1'b1;
      tick();
      chk_all("restart_wait", 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1);
      inst_addr_ok = 1'b0;
      inst_data_ok = 1'b1;
      inst_rdata   = 32'h66666666;
      stall        = 6'd2;
      tick();
      drive_idle();
      stall = 6'd2;
      chk_all("restart_hold", 1'b0, 32'h0, 32'hBFC00000, 32'h66666666, 32'h0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
